seven_seg_scanner: RTL and testbench

//  Downstream of the calculator arithmetic stage. Latches its four BCD result

---
 rtl/seven_seg_scanner.sv | 105 ++++++++++
 tb/tb_seven_seg_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: latches four result digits and time-multiplexes them
// onto a 4-digit common-anode display with dead-time and zero blanking.
module seven_seg_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int DEAD_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    shd [0:3];
    logic          wrap;
    logic          blank;
    logic [3:0]    dig;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wrap = (cnt == CW'(SCAN_DIV - 1));
    assign dp   = 1'b1;

    // Next anode/segment pattern from the current slot phase and digit.
    always_comb begin
        dig    = shd[idx];
        blank  = 1'b0;
        an_nx  = 4'b1111;
        seg_nx = 7'b1111111;
        if (blank_lz) begin
            case (idx)
                2'd0: blank = (shd[0] == 4'd0);
                2'd1: blank = (shd[0] == 4'd0) && (shd[1] == 4'd0);
                2'd2: blank = (shd[0] == 4'd0) && (shd[1] == 4'd0)
                              && (shd[2] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
        if (cnt >= CW'(DEAD_CYC)) begin
            an_nx  = ~(4'b1000 >> idx);
            seg_nx = blank ? 7'b1111111 : decode(dig);
        end
    end

    // Shadow capture, slot timing and registered display outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shd        <= '{default: 4'd0};
            cnt        <= '0;
            idx        <= 2'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                shd[0] <= digit1;
                shd[1] <= digit2;
                shd[2] <= digit3;
                shd[3] <= digit4;
            end
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap) begin
                idx <= idx + 2'd1;
            end
            frame_tick <= wrap && (idx == 2'd3);
            an         <= an_nx;
            seg        <= seg_nx;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed stimulus with a cycle-stamped expectation
// queue drained by an independent negedge monitor.
module tb_seven_seg_scanner;

    localparam int SD = 8;
    localparam int DC = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    seven_seg_scanner #(.SCAN_DIV(SD), .DEAD_CYC(DC)) dut (
        .clk(clk), .reset_n(reset_n), .load(load),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   started = 0;
    int   base;

    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic expect_at(input int k, input logic [3:0] a,
                             input logic [6:0] s, input logic f,
                             input string n);
        exp_t x;
        x.k = k; x.an = a; x.seg = s; x.ft = f; x.name = n;
        q.push_back(x);
    endtask

    // Slot i of the frame starting at f: dead, first ON, last ON.
    task automatic exp_slot(input int f, input int i,
                            input logic [6:0] s, input string n);
        logic [3:0] a;
        a = ~(4'b1000 >> i);
        expect_at(f + 8*i + 2, 4'b1111, S_OFF, 1'b0, {n, "_dead"});
        expect_at(f + 8*i + 3, a, s, 1'b0, {n, "_on1"});
        expect_at(f + 8*i + 8, a, s, (i == 3), {n, "_on6"});
    endtask

    task automatic exp_frame(input int f, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input string n);
        exp_slot(f, 0, s0, {n, "_d1"});
        exp_slot(f, 1, s1, {n, "_d2"});
        exp_slot(f, 2, s2, {n, "_d3"});
        exp_slot(f, 3, s3, {n, "_d4"});
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        digit1 = a; digit2 = b; digit3 = c; digit4 = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Monitor: structural checks every cycle, scoreboard pops when due.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (!$onehot0(~an) || dp !== 1'b1) begin
                fails++;
                $display("FAIL anode_excl cyc=%0d an=%b dp=%b required one-hot-low an, dp=1",
                         cyc, an, dp);
            end
            while (q.size() > 0 && q[0].k <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.k < cyc) begin
                    fails++;
                    $display("FAIL %s missed at cyc=%0d (due %0d)", e.name, cyc, e.k);
                end else if (an !== e.an || seg !== e.seg || frame_tick !== e.ft) begin
                    fails++;
                    $display("FAIL %s cyc=%0d got an=%b seg=%b ft=%b required an=%b seg=%b ft=%b",
                             e.name, cyc, an, seg, frame_tick, e.an, e.seg, e.ft);
                end
            end
        end
    end

    initial begin
        int f;
        reset_n  = 1'b0;
        load     = 1'b1;
        blank_lz = 1'b0;
        digit1 = 4'd5; digit2 = 4'd5; digit3 = 4'd5; digit4 = 4'd5;

        for (int i = 0; i < 3; i++) begin
            expect_at(cyc + 1, 4'b1111, S_OFF, 1'b0, "reset_hold");
            tick();
            started = 1;
        end
        base    = cyc;
        reset_n = 1'b1;
        load    = 1'b0;
        expect_at(base + 1, 4'b1111, S_OFF, 1'b0, "post_rst_dead");
        exp_frame(base, S0, S0, S0, S0, "f0_zero");

        f = base + 32;
        run_to(f);
        exp_frame(f, S1, S2, S3, S4, "f1_1234");
        do_load(4'd1, 4'd2, 4'd3, 4'd4);

        f = base + 64;
        run_to(f);
        exp_frame(f, S_OFF, S_OFF, S_OFF, S7, "f2_lz0007");
        blank_lz = 1'b1;
        do_load(4'd0, 4'd0, 4'd0, 4'd7);

        f = base + 96;
        run_to(f);
        exp_frame(f, S_OFF, S_OFF, S_OFF, S0, "f3_lz0000");
        do_load(4'd0, 4'd0, 4'd0, 4'd0);

        f = base + 128;
        run_to(f);
        exp_frame(f, S_OFF, S1, S0, S0, "f4_lz0100");
        do_load(4'd0, 4'd1, 4'd0, 4'd0);

        f = base + 160;
        run_to(f);
        exp_slot(f, 0, S9, "f5_d1");
        exp_slot(f, 1, S9, "f5_d2");
        exp_slot(f, 2, S9, "f5_d3");
        expect_at(f + 26, 4'b1111, S_OFF, 1'b0, "f5_d4_dead");
        expect_at(f + 27, 4'b1110, S9, 1'b0, "f5_d4_old");
        expect_at(f + 28, 4'b1110, S9, 1'b0, "f5_load_edge");
        expect_at(f + 29, 4'b1110, S8, 1'b0, "f5_new_seg");
        expect_at(f + 32, 4'b1110, S8, 1'b1, "f5_tick");
        blank_lz = 1'b0;
        do_load(4'd9, 4'd9, 4'd9, 4'd9);
        run_to(f + 27);
        do_load(4'd0, 4'd1, 4'd9, 4'd8);

        f = base + 192;
        run_to(f);
        exp_slot(f, 0, S0, "f6_d1");
        exp_slot(f, 1, S1, "f6_d2");
        run_to(f + 21);
        reset_n = 1'b0;
        expect_at(cyc + 1, 4'b1111, S_OFF, 1'b0, "mid_reset");
        tick();
        base    = cyc;
        reset_n = 1'b1;
        expect_at(base + 1, 4'b1111, S_OFF, 1'b0, "mid_post_dead");
        exp_frame(base, S0, S0, S0, S0, "f7_cleared");
        expect_at(base + 33, 4'b1111, S_OFF, 1'b0, "f8_tick_off");
        run_to(base + 34);

        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            fails++;
            $display("FAIL drain %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
